// File: rtl/output_buffer.sv
// output_buffer
//   Memory-mapped output register block on one 64 KiB I/O page. It holds the
//   red/green LED registers, two packed seven-segment words (HEX0-3 and
//   HEX4-7) and an LCD control/data register. Every access is accepted in a
//   single cycle. Every output comes straight from a flop.
//
// Ports
//   i_clk               clock; all state changes on its rising edge
//   i_reset             synchronous, active-high reset
//   i_addr[31:0]        byte address: [31:16] page, [15:12] register, [1:0] must be 0
//   i_wdata[31:0]       store data
//   i_bmask[3:0]        store byte enables
//   i_wren, i_rden      one-cycle store / load strobes
//   o_rdata[31:0]       load data, valid while o_rvalid is high, otherwise holds
//   o_rvalid            one-cycle load response pulse
//   o_err               one-cycle pulse after an illegal access
//   o_io_ledr/ledg/lcd  32-bit register contents
//   o_io_hex0..7        active-low segment patterns (bit 7 of each byte not driven)
module output_buffer #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  input  logic        i_wren,
  input  logic        i_rden,
  output logic [31:0] o_rdata,
  output logic        o_rvalid,
  output logic        o_err,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd
);

  // Register index order: 0 LEDR, 1 LEDG, 2 HEX0-3, 3 HEX4-7, 4 LCD
  localparam int NREG = 5;

  logic [3:0]  sel;
  logic        page_hit;
  logic        aligned;
  logic        in_map;
  logic        legal;
  logic        access;
  logic        wr_ok;
  logic        rd_ok;
  logic [31:0] rd_mux;
  logic [31:0] rdata_reg;
  logic        rvalid_reg;
  logic        err_reg;
  logic        unused_addr_bits;

  assign sel      = i_addr[15:12];
  assign page_hit = (i_addr[31:16] == BASE_ADDR[31:16]);
  assign aligned  = (i_addr[1:0] == 2'b00);
  assign in_map   = (sel <= 4'd4);
  assign legal    = page_hit && aligned && in_map;
  assign access   = i_wren || i_rden;
  assign wr_ok    = i_wren && legal;
  assign rd_ok    = i_rden && legal;

  // Word offset bits inside a register window do not take part in decode.
  assign unused_addr_bits = ^i_addr[11:2];

  genvar gi, gb;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      // Seven-segment words reset to all ones so every segment starts dark.
      localparam logic [31:0] RST_VAL = (gi == 2 || gi == 3) ? 32'hFFFF_FFFF : 32'h0000_0000;

      logic [31:0] value_reg;
      logic [31:0] merged;
      logic        hit;

      assign hit = wr_ok && (sel == 4'(gi));

      for (gb = 0; gb < 4; gb++) begin : g_byte
        assign merged[8*gb +: 8] = i_bmask[gb] ? i_wdata[8*gb +: 8] : value_reg[8*gb +: 8];
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          value_reg <= RST_VAL;
        end else if (hit) begin
          value_reg <= merged;
        end
      end
    end
  endgenerate

  // Read mux sees the pre-store value, so a same-cycle load and store to one
  // register returns the old contents.
  always_comb begin
    rd_mux = 32'h0000_0000;
    case (sel[2:0])
      3'd0:    rd_mux = g_reg[0].value_reg;
      3'd1:    rd_mux = g_reg[1].value_reg;
      3'd2:    rd_mux = g_reg[2].value_reg;
      3'd3:    rd_mux = g_reg[3].value_reg;
      3'd4:    rd_mux = g_reg[4].value_reg;
      default: rd_mux = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rdata_reg  <= 32'h0000_0000;
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      rvalid_reg <= rd_ok;
      err_reg    <= access && !legal;
      if (rd_ok) begin
        rdata_reg <= rd_mux;
      end
    end
  end

  assign o_rdata   = rdata_reg;
  assign o_rvalid  = rvalid_reg;
  assign o_err     = err_reg;
  assign o_io_ledr = g_reg[0].value_reg;
  assign o_io_ledg = g_reg[1].value_reg;
  assign o_io_lcd  = g_reg[4].value_reg;
  assign o_io_hex0 = g_reg[2].value_reg[6:0];
  assign o_io_hex1 = g_reg[2].value_reg[14:8];
  assign o_io_hex2 = g_reg[2].value_reg[22:16];
  assign o_io_hex3 = g_reg[2].value_reg[30:24];
  assign o_io_hex4 = g_reg[3].value_reg[6:0];
  assign o_io_hex5 = g_reg[3].value_reg[14:8];
  assign o_io_hex6 = g_reg[3].value_reg[22:16];
  assign o_io_hex7 = g_reg[3].value_reg[30:24];

endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, is the I/O page base; register offsets below are relative to it.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_addr  input  32  byte address of the access.
REQ-005 i_wdata  input  32  store data.
REQ-006 i_bmask  input  4  byte enables for stores; bit n selects i_wdata[8n+7:8n].
REQ-007 i_wren  input  1  store request, one cycle per access.
REQ-008 i_rden  input  1  load request, one cycle per access.
REQ-009 o_rdata  output  32  load data, registered.
REQ-010 o_rvalid  output  1  one-cycle pulse qualifying o_rdata.
REQ-011 o_err  output  1  one-cycle pulse on an illegal access.
REQ-012 o_io_ledr  output  32  red LED register.
REQ-013 o_io_ledg  output  32  green LED register.
REQ-014 o_io_hex0..o_io_hex7  output  7 each  seven-segment segment patterns, active-low.
REQ-015 o_io_lcd  output  32  LCD control/data register.

Function
REQ-016 Register map: LEDR offset 0x0000, LEDG 0x1000, HEX0-3 0x2000, HEX4-7 0x3000, LCD 0x4000. Decode: i_addr[31:16] equal to BASE_ADDR[31:16], i_addr[15:12] selects the register, i_addr[11:2] ignored.
REQ-017 HEX0-3 word layout: byte k holds HEXk in bits [8k+6:8k]. Bit 8k+7 is stored and read back but not driven out. HEX4-7 uses the same layout for HEX4..HEX7.
REQ-018 Store with i_wren=1 to a mapped register: update only the bytes enabled in i_bmask at the rising edge. Outputs reflect the new value in the following cycle. i_bmask=0 is a legal no-op.
REQ-019 Load with i_rden=1 to a mapped register: o_rdata equals the full 32-bit register value and o_rvalid=1 in the next cycle (latency 1). Otherwise o_rvalid=0 and o_rdata holds its last value.
REQ-020 Simultaneous i_wren and i_rden to the same register: the load returns the pre-store value; the store still takes effect.
REQ-021 Back-to-back accesses are accepted every cycle; no stall and no ready signal.
REQ-022 Illegal access: i_addr[1:0] != 0, i_addr[15:12] > 4, or i_addr[31:16] mismatch while i_wren or i_rden is asserted.
REQ-023 On an illegal access: no register changes, o_err=1 for exactly the next cycle, and o_rvalid=0 even if i_rden was asserted.
REQ-024 Accesses with neither i_wren nor i_rden asserted have no effect and never raise o_err.
REQ-025 All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

Reset
REQ-026 While i_reset=1 at a clock edge:
- LEDR, LEDG, LCD clear to 0.
- HEX registers load 32'hFFFF_FFFF (all segments off).
- o_rdata=0, o_rvalid=0, o_err=0.
REQ-027 Reset has priority over a concurrent store or load; that access is discarded and produces no o_rvalid or o_err in the following cycle.
REQ-028 Asserting reset mid-sequence discards any response due in the next cycle.

Verification
REQ-029 Reset, then load LEDR and HEX0-3 -> o_rdata = 0x0000_0000, then 0xFFFF_FFFF, each with a one-cycle o_rvalid pulse.
REQ-030 Store 0xDEAD_BEEF to LEDG with i_bmask=4'b0101 after reset -> o_io_ledg = 0x00AD_00EF.
REQ-031 Store 0x4079_2430 to HEX0-3 with full mask -> o_io_hex0=7'h30, o_io_hex1=7'h24, o_io_hex2=7'h79, o_io_hex3=7'h40.
REQ-032 Same-cycle store 0x1234_5678 and load on LEDR holding 0x0000_00FF -> o_rdata = 0x0000_00FF; a following load returns 0x1234_5678.
REQ-033 Store to BASE_ADDR+0x5000, and separately to BASE_ADDR+0x0002 -> o_err pulses one cycle for each, all registers unchanged, o_rvalid stays 0.
REQ-034 Store 0xFFFF_FFFF to LCD, assert i_reset with a concurrent load -> o_io_lcd = 0 next cycle, no o_rvalid pulse.
